// File: rtl/vga_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_layer_scheduler
// Purpose  : Pixel-pipeline sequencer for the tic-tac-toe VGA display.
//            Divides clk by two into a pixel tick, runs 640x480@60 timing
//            counters, decodes the four display layers for the current
//            pixel and double-buffers board/cursor updates so that they
//            only take effect at the start of vertical blank.
// Ports    : clk          - system clock (50 MHz)
//            rst_n        - asynchronous active-low reset
//            upd_req      - level request to load board_in/cursor_in
//            board_in     - 9 cells x 2 bits (00 empty, 01 P1, 10 P2, 11 empty)
//            cursor_in    - pointer cell 0..8, 9..15 = no pointer
//            upd_ack      - one-clk pulse when the update is latched
//            hsync/vsync  - active-low syncs
//            h_count/v_count - coordinates of the pixel being shown
//            active       - pixel lies inside the visible area
//            visible      - {pointer, lines, sprite2, sprite1}
//            frame_start  - one-clk pulse when counters wrap to (0,0)
// Revision : 1.0 - initial release
// ============================================================================
module vga_layer_scheduler #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int BOARD_X0   = 80,
    parameter int CELL       = 160,
    parameter int SPR_MARGIN = 20,   // sprite inset from each cell edge
    parameter int PTR_MARGIN = 8,    // pointer frame inset from each cell edge
    parameter int PTR_WIDTH  = 4     // pointer frame stroke width
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_req,
    input  logic [17:0] board_in,
    input  logic [3:0]  cursor_in,
    output logic        upd_ack,
    output logic        hsync,
    output logic        vsync,
    output logic [9:0]  h_count,
    output logic [9:0]  v_count,
    output logic        active,
    output logic [3:0]  visible,
    output logic        frame_start
);

    localparam logic [9:0] c_h_max     = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_v_max     = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_h_vis     = 10'(H_VISIBLE);
    localparam logic [9:0] c_v_vis     = 10'(V_VISIBLE);
    localparam logic [9:0] c_hs_lo     = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] c_hs_hi     = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_vs_lo     = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] c_vs_hi     = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [9:0] c_bx0       = 10'(BOARD_X0);
    localparam logic [9:0] c_bx1       = 10'(BOARD_X0 + 3 * CELL - 1);
    localparam logic [9:0] c_by1       = 10'(3 * CELL - 1);
    localparam logic [9:0] c_cell      = 10'(CELL);
    localparam logic [9:0] c_cell2     = 10'(2 * CELL);
    localparam logic [9:0] c_l1_lo     = 10'(CELL - 2);
    localparam logic [9:0] c_l1_hi     = 10'(CELL + 1);
    localparam logic [9:0] c_l2_lo     = 10'(2 * CELL - 2);
    localparam logic [9:0] c_l2_hi     = 10'(2 * CELL + 1);
    localparam logic [9:0] c_spr_lo    = 10'(SPR_MARGIN);
    localparam logic [9:0] c_spr_hi    = 10'(CELL - 1 - SPR_MARGIN);
    localparam logic [9:0] c_ptr_lo    = 10'(PTR_MARGIN);
    localparam logic [9:0] c_ptr_hi    = 10'(CELL - 1 - PTR_MARGIN);
    localparam logic [9:0] c_ptr_in_lo = 10'(PTR_MARGIN + PTR_WIDTH - 1);
    localparam logic [9:0] c_ptr_in_hi = 10'(CELL - PTR_MARGIN - PTR_WIDTH);

    function automatic logic in_rng(input logic [9:0] x, input logic [9:0] lo,
                                    input logic [9:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        tick_q;
    logic [9:0]  h_q, v_q;
    logic        hsync_q, vsync_q, active_q;
    logic [3:0]  visible_q;
    logic        ack_q, fs_q;
    logic [17:0] board_q;
    logic [3:0]  cursor_q;

    // ------------------------------------------------------------------
    // Next pixel position. Everything registered on a tick is decoded
    // from this position so that counters, syncs and layers stay aligned.
    // ------------------------------------------------------------------
    logic [9:0] h_d, v_d;

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == c_h_max) begin
            h_d = '0;
            v_d = (v_q == c_v_max) ? 10'd0 : v_q + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Layer decode. Cell column/row come from two comparisons per axis;
    // the local offset is the board offset minus the selected cell base.
    // ------------------------------------------------------------------
    logic [9:0] bx, lx, ly;
    logic [1:0] col, row;
    logic [3:0] cell_idx;
    logic [1:0] cell_code;
    logic       active_d, in_board, line_hit, spr_win, ptr_win, ptr_edge;
    logic       hsync_d, vsync_d;
    logic [3:0] visible_d;

    always_comb begin
        bx       = h_d - c_bx0;
        active_d = (h_d < c_h_vis) && (v_d < c_v_vis);
        in_board = active_d && (h_d >= c_bx0) && (h_d <= c_bx1) && (v_d <= c_by1);

        if (bx < c_cell) begin
            col = 2'd0;
            lx  = bx;
        end else if (bx < c_cell2) begin
            col = 2'd1;
            lx  = bx - c_cell;
        end else begin
            col = 2'd2;
            lx  = bx - c_cell2;
        end

        if (v_d < c_cell) begin
            row = 2'd0;
            ly  = v_d;
        end else if (v_d < c_cell2) begin
            row = 2'd1;
            ly  = v_d - c_cell;
        end else begin
            row = 2'd2;
            ly  = v_d - c_cell2;
        end

        // row*3 + col without a multiplier
        cell_idx  = {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
        cell_code = 2'(board_q >> {cell_idx, 1'b0});

        line_hit = in_rng(bx, c_l1_lo, c_l1_hi) || in_rng(bx, c_l2_lo, c_l2_hi) ||
                   in_rng(v_d, c_l1_lo, c_l1_hi) || in_rng(v_d, c_l2_lo, c_l2_hi);
        spr_win  = in_rng(lx, c_spr_lo, c_spr_hi) && in_rng(ly, c_spr_lo, c_spr_hi);
        ptr_win  = in_rng(lx, c_ptr_lo, c_ptr_hi) && in_rng(ly, c_ptr_lo, c_ptr_hi);
        ptr_edge = (lx <= c_ptr_in_lo) || (lx >= c_ptr_in_hi) ||
                   (ly <= c_ptr_in_lo) || (ly >= c_ptr_in_hi);

        visible_d = 4'b0000;
        if (in_board) begin
            visible_d[0] = spr_win && (cell_code == 2'b01);
            visible_d[1] = spr_win && (cell_code == 2'b10);
            visible_d[2] = line_hit;
            // cursor values 9..15 never equal a cell index, so no pointer
            visible_d[3] = ptr_win && ptr_edge && (cursor_q == cell_idx);
        end

        hsync_d = !in_rng(h_d, c_hs_lo, c_hs_hi);
        vsync_d = !in_rng(v_d, c_vs_lo, c_vs_hi);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q    <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            active_q  <= 1'b0;
            visible_q <= 4'b0000;
            ack_q     <= 1'b0;
            fs_q      <= 1'b0;
            board_q   <= '0;
            cursor_q  <= 4'hF;
        end else begin
            tick_q <= ~tick_q;
            ack_q  <= 1'b0;
            fs_q   <= 1'b0;
            if (tick_q) begin
                h_q       <= h_d;
                v_q       <= v_d;
                hsync_q   <= hsync_d;
                vsync_q   <= vsync_d;
                active_q  <= active_d;
                visible_q <= visible_d;
                // (0,0) is only ever reached by wrapping from the last pixel
                fs_q      <= (h_d == 10'd0) && (v_d == 10'd0);
                // shadow loads only when entering vertical blank
                if (upd_req && (h_d == 10'd0) && (v_d == c_v_vis)) begin
                    board_q  <= board_in;
                    cursor_q <= cursor_in;
                    ack_q    <= 1'b1;
                end
            end
        end
    end

    assign h_count     = h_q;
    assign v_count     = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign visible     = visible_q;
    assign upd_ack     = ack_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_layer_scheduler
// Purpose  : Self-checking bench for vga_layer_scheduler, run on a reduced
//            raster (104x80 total, 88x72 visible, 24-pixel cells) so several
//            frames fit in a short simulation. A reference model tracks the
//            raster and shadow registers; expected ack positions go through
//            a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_layer_scheduler;

    localparam int HV = 88, HFP = 4, HS = 6, HBP = 6;
    localparam int VV = 72, VFP = 3, VS = 2, VBP = 3;
    localparam int X0 = 8, C = 24, SM = 4, PM = 2, PW = 2;
    localparam int HT = HV + HFP + HS + HBP;   // 104
    localparam int VT = VV + VFP + VS + VBP;   // 80
    localparam int FRAME_CLK = 2 * HT * VT;    // 16640
    localparam int LIMIT = 2 * FRAME_CLK + 100;

    logic        clk, rst_n, upd_req;
    logic [17:0] board_in;
    logic [3:0]  cursor_in;
    logic        upd_ack, hsync, vsync, active, frame_start;
    logic [9:0]  h_count, v_count;
    logic [3:0]  visible;

    vga_layer_scheduler #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .BOARD_X0(X0), .CELL(C), .SPR_MARGIN(SM), .PTR_MARGIN(PM), .PTR_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .upd_req(upd_req), .board_in(board_in),
        .cursor_in(cursor_in), .upd_ack(upd_ack), .hsync(hsync), .vsync(vsync),
        .h_count(h_count), .v_count(v_count), .active(active), .visible(visible),
        .frame_start(frame_start)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];   // expected ack position, v*HT+h

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nxt_h(input int h);
        return (h == HT - 1) ? 0 : h + 1;
    endfunction

    function automatic int nxt_v(input int h, input int v);
        return (h == HT - 1) ? ((v == VT - 1) ? 0 : v + 1) : v;
    endfunction

    function automatic logic [3:0] exp_vis(input int h, input int v,
                                           input logic [17:0] b, input logic [3:0] cur);
        logic [3:0] r;
        int bx, col, row, lx, ly, idx, code;
        logic spr, pw, pe;
        r = 4'b0000;
        if (h < HV && v < VV && h >= X0 && h < X0 + 3 * C && v < 3 * C) begin
            bx = h - X0;
            col = bx / C;  row = v / C;
            lx = bx % C;   ly = v % C;
            idx = row * 3 + col;
            code = int'((b >> (2 * idx)) & 18'h3);
            if ((bx >= C - 2 && bx <= C + 1) || (bx >= 2 * C - 2 && bx <= 2 * C + 1) ||
                (v >= C - 2 && v <= C + 1) || (v >= 2 * C - 2 && v <= 2 * C + 1))
                r[2] = 1'b1;
            spr = (lx >= SM && lx <= C - 1 - SM && ly >= SM && ly <= C - 1 - SM);
            if (spr && code == 1) r[0] = 1'b1;
            if (spr && code == 2) r[1] = 1'b1;
            pw = (lx >= PM && lx <= C - 1 - PM && ly >= PM && ly <= C - 1 - PM);
            pe = (lx < PM + PW) || (lx > C - 1 - PM - PW) ||
                 (ly < PM + PW) || (ly > C - 1 - PM - PW);
            if (pw && pe && int'(cur) == idx) r[3] = 1'b1;
        end
        return r;
    endfunction

    bit          m_tick, m_run, m_ack;
    int          mh, mv;
    logic [17:0] m_board;
    logic [3:0]  m_cur;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tick  <= 1'b0;
            m_run   <= 1'b0;
            m_ack   <= 1'b0;
            mh      <= 0;
            mv      <= 0;
            m_board <= '0;
            m_cur   <= 4'hF;
        end else begin
            m_tick <= ~m_tick;
            m_ack  <= 1'b0;
            if (m_tick) begin
                mh    <= nxt_h(mh);
                mv    <= nxt_v(mh, mv);
                m_run <= 1'b1;
                if (upd_req && nxt_h(mh) == 0 && nxt_v(mh, mv) == VV) begin
                    m_board <= board_in;
                    m_cur   <= cursor_in;
                    m_ack   <= 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle monitor ----------------
    initial begin
        int cyc;
        int last_fs;
        cyc = 0;
        last_fs = -1;
        forever begin
            @(negedge clk);
            cyc++;
            chk("h_count", h_count, mh);
            chk("v_count", v_count, mv);
            chk("hsync", hsync, !(mh >= HV + HFP && mh <= HV + HFP + HS - 1));
            chk("vsync", vsync, !(mv >= VV + VFP && mv <= VV + VFP + VS - 1));
            chk("active", active, m_run && mh < HV && mv < VV);
            chk("visible", visible, m_run ? exp_vis(mh, mv, m_board, m_cur) : 4'b0000);
            chk("frame_start", frame_start, m_run && mh == 0 && mv == 0 && !m_tick);
            chk("upd_ack", upd_ack, m_ack);
            if (!rst_n) last_fs = -1;
            if (frame_start) begin
                if (last_fs >= 0) chk("frame_period", cyc - last_fs, FRAME_CLK);
                last_fs = cyc;
            end
            if (upd_ack) begin
                chk("ack_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("ack_pos", v_count * HT + h_count, exp_q.pop_front());
            end
        end
    end

    // ---------------- directed-step helpers ----------------
    task automatic wait_pixel(input int h, input int v);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < LIMIT; n++) begin
            @(negedge clk);
            if (h_count == h && v_count == v) begin
                hit = 1'b1;
                break;
            end
        end
        chk("pixel_reached", hit, 1);
    endtask

    task automatic wait_ack();
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < LIMIT; n++) begin
            @(negedge clk);
            if (upd_ack) begin
                hit = 1'b1;
                break;
            end
        end
        chk("ack_seen", hit, 1);
        chk("ack_at_h0", h_count, 0);
        chk("ack_at_vblank", v_count, VV);
        upd_req = 1'b0;
        @(negedge clk);
        chk("ack_width", upd_ack, 0);
    endtask

    task automatic check_px(input int h, input int v, input logic [3:0] vis, input logic act);
        wait_pixel(h, v);
        chk("px_visible", visible, vis);
        chk("px_active", active, act);
    endtask

    task automatic request(input logic [17:0] b, input logic [3:0] cur);
        upd_req   = 1'b1;
        board_in  = b;
        cursor_in = cur;
        exp_q.push_back(VV * HT);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        upd_req   = 1'b0;
        board_in  = '0;
        cursor_in = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_visible", visible, 0);
        chk("rst_h", h_count, 0);
        chk("rst_v", v_count, 0);
        chk("rst_ack", upd_ack, 0);
        chk("rst_active", active, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_edge_h", h_count, 0);
        @(posedge clk); #1;
        chk("second_edge_h", h_count, 1);

        // frame 0: mid-frame request, held until acked at vblank
        wait_pixel(0, 10);
        request(18'h00001, 4'd4);
        wait_ack();

        // frame 1: new board visible
        check_px(32, 2, 4'b0100, 1'b1);
        check_px(4, 12, 4'b0000, 1'b1);
        check_px(20, 12, 4'b0001, 1'b1);
        check_px(95, 12, 4'b0000, 1'b0);
        check_px(35, 34, 4'b1000, 1'b1);

        // cell 8 = player 2, cell 1 = code 11, cursor out of range
        request(18'h2000C, 4'd12);
        wait_ack();
        check_px(44, 12, 4'b0000, 1'b1);
        check_px(35, 34, 4'b0000, 1'b1);
        check_px(68, 60, 4'b0010, 1'b1);

        // asynchronous reset mid-frame with a request outstanding
        wait_pixel(0, 64);
        request(18'h00000, 4'd0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_h", h_count, 0);
        chk("mid_rst_v", v_count, 0);
        chk("mid_rst_hsync", hsync, 1);
        chk("mid_rst_visible", visible, 0);
        chk("mid_rst_active", active, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ack();
        check_px(10, 12, 4'b1000, 1'b1);
        check_px(20, 12, 4'b0000, 1'b1);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/vga_layer_scheduler.md
Name: vga_layer_scheduler

Overview:
- Sequences the VGA pixel pipeline for the tic-tac-toe display.
- Divides the system clock to a pixel tick and runs 640x480@60 timing counters.
- Drives the 4-bit layer `visible` vector consumed by the RGB decoder (sprite 1, sprite 2, grid lines, pointer).
- Takes board and cursor updates from game logic through a req/ack handshake and applies them only at vertical blank, so frames never tear.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- BOARD_X0, 80, left edge of the 480x480 board
- CELL, 160, cell size in pixels

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous, active-low reset
- upd_req  in  1  level request to load a new board/cursor
- board_in  in  18  cell i at bits [2i+1:2i]; 00 empty, 01 player1, 10 player2, 11 treated as empty
- cursor_in  in  4  cursor cell 0..8, row-major; values 9..15 mean no pointer
- upd_ack  out  1  one-clk pulse when the update is latched
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- h_count  out  10  current pixel x
- v_count  out  10  current pixel y
- active  out  1  1 when h_count < H_VISIBLE and v_count < V_VISIBLE
- visible  out  4  bit0 sprite1, bit1 sprite2, bit2 lines, bit3 pointer
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0)

Behaviour:
- Reset, asynchronous on rst_n low:
  - tick toggle, counters, visible, active, upd_ack, frame_start = 0; hsync = vsync = 1.
  - Shadow board = 0; shadow cursor = 15 (no pointer).
- Pixel tick:
  - A toggle flop produces tick = 1 every 2nd clk (first tick on the 2nd clk after reset release).
  - All outputs except upd_ack and frame_start change only on the clk edge where tick = 1.
- Counters:
  - h wraps at 799 (H_VISIBLE+H_FP+H_SYNC+H_BP-1) to 0; v increments on h wrap.
  - v wraps at 524 to 0.
  - Frame length is 800*525 ticks = 840000 clk.
- Syncs:
  - hsync = 0 for h in [656,751].
  - vsync = 0 for v in [490,491].
- Alignment: h_count, v_count, hsync, vsync, active and visible are registered together in one stage and always describe the same pixel.
- Layer decode:
  - Requires active = 1 and h in [BOARD_X0, BOARD_X0+479]; otherwise visible = 0000.
  - bx = h - BOARD_X0 and by = v; col = bx/CELL and row = by/CELL, found by comparators with no divider; lx and ly are the local offsets within the cell.
  - Lines (bit2): bx or by in [158,161] or [318,321].
  - Sprites: if the shadow cell code is 01, bit0 = 1 when lx and ly are both in [20,139]. If the code is 10, bit1 = 1 under the same condition.
  - Pointer (bit3): cell index = shadow cursor, both lx and ly in [8,151], and lx or ly in [8,11] or [148,151].
  - Bits are independent; priority belongs to the RGB decoder.
- Update handshake:
  - The requester holds upd_req = 1 with board_in/cursor_in stable until it sees upd_ack.
  - On the tick where h = 0 and v = V_VISIBLE (vblank start) with upd_req = 1: latch board_in and cursor_in into the shadow registers and pulse upd_ack for exactly 1 clk.
  - A request still high in a later frame is latched again at that frame's vblank.
  - A request raised mid-frame waits for the next vblank.
  - Shadow values never change during v < V_VISIBLE.
- frame_start: 1-clk pulse on the tick edge where the counters go (799,524) -> (0,0).
- Reset mid-frame returns to the reset values immediately; an outstanding request is not acked until the first vblank after reset.

Test Plan:
- Reset: hold rst_n = 0, sample -> hsync = vsync = 1, visible = 0000, counters 0, upd_ack = 0. Release -> first counter increment 2 clk later.
- Timing: run 2 frames -> hsync low exactly 96 ticks per line starting at h = 656; vsync low for lines 490-491; frame_start period exactly 840000 clk.
- Handshake: raise upd_req at v = 100 with board_in = 18'h00001 and cursor_in = 4 -> no ack until v = 480, h = 0; upd_ack 1 clk wide; the next frame shows the new board.
- Layers after the board above is loaded:
  - (h = 160, v = 80) -> 0001.
  - (h = 240, v = 10) -> 0100.
  - (h = 249, v = 210) -> 1000.
  - (h = 20, v = 80) -> 0000.
  - (h = 700, v = 80) -> 0000, active = 0.
- Codes: board cell 8 = 10 -> (h = 480, v = 400) -> 0010. Cell code 11 or cursor_in = 12 -> no sprite or pointer bits anywhere.
- Reset mid-frame at v = 300 with upd_req high -> outputs reset asynchronously; ack arrives at the first subsequent v = 480.
